// File: rtl/im2col_pkg.sv
// Shared defaults, FSM state encoding and sizing helpers for the im2col column streamer.
package im2col_pkg;

  localparam int unsigned IMG_W_DEF  = 28;
  localparam int unsigned IMG_H_DEF  = 28;
  localparam int unsigned K_DEF      = 3;
  localparam int unsigned DW_DEF     = 8;
  localparam int unsigned OUT_W_DEF  = IMG_W_DEF - K_DEF + 1;
  localparam int unsigned OUT_H_DEF  = IMG_H_DEF - K_DEF + 1;
  localparam int unsigned ADDR_W_DEF = $clog2(IMG_W_DEF * IMG_H_DEF);
  localparam int unsigned IDX_W_DEF  = $clog2(OUT_W_DEF * OUT_H_DEF);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    CAP   = 3'd2,
    OUT   = 3'd3,
    DONE  = 3'd4
  } state_e;

  function automatic int unsigned num_taps(input int unsigned k);
    return k * k;
  endfunction

  // Counter width that stays >= 1 even for a range of a single value.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/im2col_addr_gen.sv
// Window/output-position counters; produces the pixel address, tap slot and column index.
module im2col_addr_gen #(
  parameter  int unsigned IMG_W  = im2col_pkg::IMG_W_DEF,
  parameter  int unsigned IMG_H  = im2col_pkg::IMG_H_DEF,
  parameter  int unsigned K      = im2col_pkg::K_DEF,
  localparam int unsigned OUT_W  = IMG_W - K + 1,
  localparam int unsigned OUT_H  = IMG_H - K + 1,
  localparam int unsigned ADDR_W = $clog2(IMG_W * IMG_H),
  localparam int unsigned IDX_W  = $clog2(OUT_W * OUT_H),
  localparam int unsigned TAP_W  = im2col_pkg::cnt_w(K * K)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              tap_step,
  input  logic              col_step,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [IDX_W-1:0]  col_index,
  output logic [TAP_W-1:0]  tap_idx,
  output logic              last_tap,
  output logic              last_col
);
  import im2col_pkg::*;

  localparam int unsigned KC_W = cnt_w(K);
  localparam int unsigned OX_W = cnt_w(OUT_W);
  localparam int unsigned OY_W = cnt_w(OUT_H);

  logic [KC_W-1:0] kx_q, kx_d, ky_q, ky_d;
  logic [OX_W-1:0] ox_q, ox_d;
  logic [OY_W-1:0] oy_q, oy_d;

  logic kx_end, ox_end, oy_end;

  assign kx_end   = (kx_q == KC_W'(K - 1));
  assign last_tap = kx_end && (ky_q == KC_W'(K - 1));
  assign ox_end   = (ox_q == OX_W'(OUT_W - 1));
  assign oy_end   = (oy_q == OY_W'(OUT_H - 1));
  assign last_col = ox_end && oy_end;

  always_comb begin
    kx_d = kx_q;
    ky_d = ky_q;
    ox_d = ox_q;
    oy_d = oy_q;
    if (clear) begin
      kx_d = '0;
      ky_d = '0;
      ox_d = '0;
      oy_d = '0;
    end else begin
      if (tap_step) begin
        if (kx_end) begin
          kx_d = '0;
          ky_d = last_tap ? '0 : ky_q + 1'b1;
        end else begin
          kx_d = kx_q + 1'b1;
        end
      end
      if (col_step) begin
        if (ox_end) begin
          ox_d = '0;
          oy_d = oy_end ? '0 : oy_q + 1'b1;
        end else begin
          ox_d = ox_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kx_q <= '0;
      ky_q <= '0;
      ox_q <= '0;
      oy_q <= '0;
    end else begin
      kx_q <= kx_d;
      ky_q <= ky_d;
      ox_q <= ox_d;
      oy_q <= oy_d;
    end
  end

  // Window origin plus in-window offset always lands inside the image since K <= IMG_W/IMG_H.
  assign mem_addr  = ADDR_W'((32'(oy_q) + 32'(ky_q)) * IMG_W + 32'(ox_q) + 32'(kx_q));
  assign col_index = IDX_W'(32'(oy_q) * OUT_W + 32'(ox_q));
  assign tap_idx   = TAP_W'(32'(ky_q) * K + 32'(kx_q));

endmodule

// File: rtl/im2col_patch_streamer.sv
// Fetches each KxK window from pixel memory and streams it as one column vector per handshake.
module im2col_patch_streamer #(
  parameter  int unsigned IMG_W  = im2col_pkg::IMG_W_DEF,
  parameter  int unsigned IMG_H  = im2col_pkg::IMG_H_DEF,
  parameter  int unsigned K      = im2col_pkg::K_DEF,
  parameter  int unsigned DW     = im2col_pkg::DW_DEF,
  localparam int unsigned OUT_W  = IMG_W - K + 1,
  localparam int unsigned OUT_H  = IMG_H - K + 1,
  localparam int unsigned ADDR_W = $clog2(IMG_W * IMG_H),
  localparam int unsigned IDX_W  = $clog2(OUT_W * OUT_H)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [DW-1:0]       mem_rd_data,
  output logic                col_valid,
  input  logic                col_ready,
  output logic [K*K*DW-1:0]   col_data,
  output logic [IDX_W-1:0]    col_index,
  output logic                col_last
);
  import im2col_pkg::*;

  localparam int unsigned TAPS  = num_taps(K);
  localparam int unsigned TAP_W = cnt_w(TAPS);

  // state | meaning
  // IDLE  | waiting for start
  // FETCH | one memory read per tap, K*K cycles
  // CAP   | last tap's read data lands in its slot
  // OUT   | column presented until accepted
  // DONE  | one-cycle completion pulse
  state_e state_q, state_d;

  logic             clear, tap_step, col_step;
  logic [TAP_W-1:0] tap_idx;
  logic             last_tap, last_col;

  logic               rd_pend_q, rd_pend_d;
  logic [TAP_W-1:0]   rd_slot_q, rd_slot_d;
  logic [K*K*DW-1:0]  col_data_q, col_data_d;

  im2col_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .K     (K)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .tap_step  (tap_step),
    .col_step  (col_step),
    .mem_addr  (mem_addr),
    .col_index (col_index),
    .tap_idx   (tap_idx),
    .last_tap  (last_tap),
    .last_col  (last_col)
  );

  always_comb begin
    state_d   = state_q;
    clear     = 1'b0;
    tap_step  = 1'b0;
    col_step  = 1'b0;
    mem_rd_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          clear   = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        mem_rd_en = 1'b1;
        tap_step  = 1'b1;
        if (last_tap) state_d = CAP;
      end
      CAP: state_d = OUT;
      OUT: begin
        if (col_ready) begin
          if (last_col) begin
            state_d = DONE;
          end else begin
            col_step = 1'b1;
            state_d  = FETCH;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data returns one cycle late, so the slot index travels with the strobe.
  always_comb begin
    rd_pend_d  = mem_rd_en;
    rd_slot_d  = tap_idx;
    col_data_d = col_data_q;
    if (rd_pend_q) col_data_d[int'(rd_slot_q)*DW +: DW] = mem_rd_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_pend_q  <= 1'b0;
      rd_slot_q  <= '0;
      col_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_pend_q  <= rd_pend_d;
      rd_slot_q  <= rd_slot_d;
      col_data_q <= col_data_d;
    end
  end

  assign busy      = (state_q == FETCH) || (state_q == CAP) || (state_q == OUT);
  assign done      = (state_q == DONE);
  assign col_valid = (state_q == OUT);
  assign col_last  = col_valid && last_col;
  assign col_data  = col_data_q;

endmodule

// File: tb/tb_im2col_patch_streamer.sv
// Directed bench for im2col_patch_streamer against a ramp-filled pixel memory.
module tb_im2col_patch_streamer;

  localparam int IMG_W = 28;
  localparam int OUT_W = 26;
  localparam int NCOL  = 676;

  logic        clk = 1'b0;
  logic        reset, start, col_ready;
  logic        busy, done, mem_rd_en, col_valid, col_last;
  logic [9:0]  mem_addr, col_index;
  logic [7:0]  mem_rd_data;
  logic [71:0] col_data;

  int vectors    = 0;
  int miscompares = 0;

  im2col_patch_streamer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .col_valid   (col_valid),
    .col_ready   (col_ready),
    .col_data    (col_data),
    .col_index   (col_index),
    .col_last    (col_last)
  );

  always #5 clk = ~clk;

  // Ramp memory: pixel = addr mod 256, one-cycle read latency.
  initial mem_rd_data = 8'h00;
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem_addr[7:0];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] pack9(input int t [9]);
    logic [71:0] v = '0;
    for (int j = 0; j < 9; j++) v[j*8 +: 8] = 8'(t[j]);
    return v;
  endfunction

  function automatic logic [71:0] model_col(input int idx);
    logic [71:0] v = '0;
    int oy = idx / OUT_W;
    int ox = idx % OUT_W;
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++)
        v[(ky*3+kx)*8 +: 8] = 8'(((oy + ky) * IMG_W + ox + kx) % 256);
    return v;
  endfunction

  task automatic test_reset();
    bit saw_rd = 0, saw_busy = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    vectors++;
    if (mem_rd_en !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_fetch: mem_rd_en=%0b expected 1", mem_rd_en);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %0b expected 0", busy); end
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %0b expected 0", done); end
    vectors++;
    if (mem_rd_en !== 1'b0) begin miscompares++; $display("FAIL rst_rd_en: got %0b expected 0", mem_rd_en); end
    vectors++;
    if (mem_addr !== 10'd0) begin miscompares++; $display("FAIL rst_addr: got %0h expected 0", mem_addr); end
    vectors++;
    if (col_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %0b expected 0", col_valid); end
    vectors++;
    if (col_data !== 72'd0) begin miscompares++; $display("FAIL rst_data: got %0h expected 0", col_data); end
    vectors++;
    if (col_index !== 10'd0) begin miscompares++; $display("FAIL rst_index: got %0d expected 0", col_index); end
    vectors++;
    if (col_last !== 1'b0) begin miscompares++; $display("FAIL rst_last: got %0b expected 0", col_last); end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_rd_en !== 1'b0) saw_rd = 1;
      if (busy !== 1'b0) saw_busy = 1;
    end
    vectors++;
    if (saw_rd) begin miscompares++; $display("FAIL idle_no_read: got read strobe expected none"); end
    vectors++;
    if (saw_busy) begin miscompares++; $display("FAIL idle_busy: got busy expected 0"); end
  endtask

  task automatic test_full_pass();
    int t0 [9]   = '{0, 1, 2, 28, 29, 30, 56, 57, 58};
    int t25 [9]  = '{25, 26, 27, 53, 54, 55, 81, 82, 83};
    int t26 [9]  = '{28, 29, 30, 56, 57, 58, 84, 85, 86};
    int t675 [9] = '{213, 214, 215, 241, 242, 243, 13, 14, 15};
    int exp_idx = 0, first_valid = -1, done_cnt = 0, done_cyc = -1;
    col_ready = 1'b1;
    start = 1'b1;
    for (int n = 1; n <= 7450; n++) begin
      tick();
      start = (n == 500) ? 1'b1 : 1'b0;
      if (col_valid === 1'b1) begin
        if (first_valid < 0) first_valid = n;
        vectors++;
        if (col_index !== 10'(exp_idx)) begin
          miscompares++;
          $display("FAIL order: col_index=%0d expected %0d at cycle %0d", col_index, exp_idx, n);
        end
        vectors++;
        if (col_data !== model_col(exp_idx)) begin
          miscompares++;
          $display("FAIL taps_%0d: got %0h expected %0h", exp_idx, col_data, model_col(exp_idx));
        end
        vectors++;
        if (col_last !== (exp_idx == NCOL - 1)) begin
          miscompares++;
          $display("FAIL last_%0d: got %0b expected %0b", exp_idx, col_last, exp_idx == NCOL - 1);
        end
        if (exp_idx == 0 || exp_idx == 25 || exp_idx == 26 || exp_idx == 675) begin
          logic [71:0] hand;
          hand = (exp_idx == 0) ? pack9(t0) : (exp_idx == 25) ? pack9(t25) :
                 (exp_idx == 26) ? pack9(t26) : pack9(t675);
          vectors++;
          if (col_data !== hand) begin
            miscompares++;
            $display("FAIL hand_taps_%0d: got %0h expected %0h", exp_idx, col_data, hand);
          end
        end
        exp_idx++;
      end
      if (n == 7436) begin
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL busy_last_out: got %0b expected 1", busy); end
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = n;
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL busy_at_done: got %0b expected 0", busy); end
      end
    end
    vectors++;
    if (first_valid != 11) begin miscompares++; $display("FAIL first_valid_cycle: got %0d expected 11", first_valid); end
    vectors++;
    if (exp_idx != NCOL) begin miscompares++; $display("FAIL column_count: got %0d expected %0d", exp_idx, NCOL); end
    vectors++;
    if (done_cnt != 1) begin miscompares++; $display("FAIL done_count: got %0d expected 1", done_cnt); end
    vectors++;
    if (done_cyc != 7437) begin miscompares++; $display("FAIL done_cycle: got %0d expected 7437", done_cyc); end
  endtask

  task automatic test_backpressure();
    logic [71:0] hold = '0;
    bit stalled = 0, seen101 = 0;
    int hs100 = 0, hs_cyc = -1;
    col_ready = 1'b1;
    start = 1'b1;
    for (int n = 1; n <= 1500 && !seen101; n++) begin
      tick();
      start = 1'b0;
      if (col_valid === 1'b1 && col_index === 10'd100 && !stalled) begin
        stalled = 1;
        col_ready = 1'b0;
        hold = col_data;
        vectors++;
        if (hold !== model_col(100)) begin
          miscompares++;
          $display("FAIL bp_taps_100: got %0h expected %0h", hold, model_col(100));
        end
        for (int s = 0; s < 5; s++) begin
          tick();
          n++;
          vectors++;
          if (col_valid !== 1'b1 || col_index !== 10'd100 || col_data !== hold || mem_rd_en !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_hold_%0d: valid=%0b idx=%0d rd_en=%0b data=%0h expected 1/100/0/%0h",
                     s, col_valid, col_index, mem_rd_en, col_data, hold);
          end
        end
        col_ready = 1'b1;
      end
      if (col_valid === 1'b1 && col_ready && col_index === 10'd100) begin
        hs100++;
        hs_cyc = n;
      end
      if (col_valid === 1'b1 && col_index === 10'd101) begin
        seen101 = 1;
        vectors++;
        if (col_data !== model_col(101)) begin
          miscompares++;
          $display("FAIL bp_taps_101: got %0h expected %0h", col_data, model_col(101));
        end
        vectors++;
        if (n - hs_cyc != 11) begin
          miscompares++;
          $display("FAIL bp_resume_latency: got %0d expected 11", n - hs_cyc);
        end
      end
    end
    vectors++;
    if (!stalled || !seen101) begin
      miscompares++;
      $display("FAIL bp_reached: stalled=%0b seen101=%0b expected 1/1", stalled, seen101);
    end
    vectors++;
    if (hs100 != 1) begin miscompares++; $display("FAIL bp_handshakes: got %0d expected 1", hs100); end
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_restart();
    bit early_done = 0, post_done = 0, post_busy = 0;
    int first_valid = -1;
    col_ready = 1'b1;
    start = 1'b1;
    for (int n = 1; n <= 3000; n++) begin
      tick();
      start = 1'b0;
      if (done === 1'b1) early_done = 1;
    end
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done !== 1'b0) post_done = 1;
      if (busy !== 1'b0) post_busy = 1;
    end
    vectors++;
    if (early_done || post_done) begin miscompares++; $display("FAIL abort_done: got done pulse expected none"); end
    vectors++;
    if (post_busy) begin miscompares++; $display("FAIL abort_busy: got busy expected 0"); end
    start = 1'b1;
    for (int n = 1; n <= 40 && first_valid < 0; n++) begin
      tick();
      start = 1'b0;
      if (col_valid === 1'b1) begin
        first_valid = n;
        vectors++;
        if (col_index !== 10'd0) begin miscompares++; $display("FAIL restart_index: got %0d expected 0", col_index); end
        vectors++;
        if (col_data !== model_col(0)) begin
          miscompares++;
          $display("FAIL restart_taps: got %0h expected %0h", col_data, model_col(0));
        end
      end
    end
    vectors++;
    if (first_valid != 11) begin miscompares++; $display("FAIL restart_valid_cycle: got %0d expected 11", first_valid); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    col_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b0;
    tick();
    test_reset();
    test_full_pass();
    test_backpressure();
    test_restart();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
